a23_cache_flush_ctrl: RTL and testbench



---
 rtl/a23_cache_pkg.sv | 16 +
 rtl/a23_cacheable_decode.sv | 18 +
 rtl/a23_cache_flush_ctrl.sv | 93 +++++++++
 tb/tb_a23_cache_flush_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/a23_cache_pkg.sv
// Shared types and constants for the A23 cache flush sequencer and cacheable decode.
package a23_cache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flush_state_t;

  // Each cacheable_area bit covers one 2 MB region of the low 64 MB.
  localparam int REGION_LSB          = 21;
  localparam int REGION_MSB          = 25;
  localparam int CACHEABLE_LIMIT_MSB = 26;

  localparam int LINES_DEFAULT = 256;

endpackage

// File: rtl/a23_cacheable_decode.sv
// Combinational region lookup: address + CP15 mask + enable -> cacheable hit.
module a23_cacheable_decode
  import a23_cache_pkg::*;
(
  input  logic        enable_i,
  input  logic [31:0] area_i,
  input  logic [31:0] address_i,
  output logic        hit_o
);

  logic [REGION_MSB-REGION_LSB:0] region;
  logic                           in_low_space;

  assign region       = address_i[REGION_MSB:REGION_LSB];
  assign in_low_space = (address_i[31:CACHEABLE_LIMIT_MSB] == '0);
  assign hit_o        = enable_i & in_low_space & area_i[region];

endmodule

// File: rtl/a23_cache_flush_ctrl.sv
// Tag RAM invalidation sweep on CP15 flush, core stall while sweeping, cacheable qualifier.
// Build option: A23_CACHE_FLUSH_ON_RESET_EN makes reset start a full sweep.
module a23_cache_flush_ctrl
  import a23_cache_pkg::*;
#(
  parameter  int LINES = LINES_DEFAULT,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cache_flush,
  input  logic             i_cache_enable,
  input  logic [31:0]      i_cacheable_area,
  input  logic [31:0]      i_address,
  input  logic             i_tag_ready,
  output logic             o_tag_wenable,
  output logic [IDX_W-1:0] o_tag_waddr,
  output logic             o_stall,
  output logic             o_flush_done,
  output logic             o_cacheable,
  output flush_state_t     o_dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  flush_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             region_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
`ifdef A23_CACHE_FLUSH_ON_RESET_EN
      state_q <= SWEEP;
`else
      state_q <= IDLE;
`endif
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // A flush request always wins: it restarts from index 0 even on the final write.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_cache_flush) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (i_cache_flush) begin
          idx_d = '0;
        end else if (i_tag_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  a23_cacheable_decode u_decode (
    .enable_i  (i_cache_enable),
    .area_i    (i_cacheable_area),
    .address_i (i_address),
    .hit_o     (region_hit)
  );

  assign o_tag_wenable = (state_q == SWEEP);
  assign o_tag_waddr   = idx_q;
  assign o_stall       = (state_q == SWEEP);
  assign o_flush_done  = done_q;
  assign o_cacheable   = region_hit & (state_q == IDLE);
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// Directed bench for a23_cache_flush_ctrl (LINES=256); sweep, restart, reset and decode cases.
module tb_a23_cache_flush_ctrl;
  import a23_cache_pkg::*;

  localparam int LINES = 256;
  localparam int BOUND = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_flush;
  logic        cache_enable;
  logic [31:0] cacheable_area;
  logic [31:0] address;
  logic        tag_ready;
  logic        tag_wenable;
  logic [7:0]  tag_waddr;
  logic        stall;
  logic        flush_done;
  logic        cacheable;
  flush_state_t dbg_state;

  int errors = 0;
  int checks = 0;

  a23_cache_flush_ctrl #(.LINES(LINES)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cache_flush    (cache_flush),
    .i_cache_enable   (cache_enable),
    .i_cacheable_area (cacheable_area),
    .i_address        (address),
    .i_tag_ready      (tag_ready),
    .o_tag_wenable    (tag_wenable),
    .o_tag_waddr      (tag_waddr),
    .o_stall          (stall),
    .o_flush_done     (flush_done),
    .o_cacheable      (cacheable),
    .o_dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_flush();
    cache_flush = 1'b1;
    step();
    cache_flush = 1'b0;
  endtask

  // Advance until waddr reaches idx while sweeping; an expired bound is a failure.
  task automatic run_to(input string tag, input int idx);
    int n = 0;
    while (!(stall === 1'b1 && tag_waddr == 8'(idx)) && n < BOUND) begin
      step();
      n++;
    end
    check(tag, {24'd0, tag_waddr}, 32'(idx));
  endtask

  // Called in the first sweep cycle with tag_ready=1: expects waddr 0..LINES-1 then one done.
  task automatic full_sweep(input string tag);
    int bad = 0;
    tag_ready = 1'b1;
    for (int i = 0; i < LINES; i++) begin
      if (tag_waddr != 8'(i) || stall !== 1'b1 || tag_wenable !== 1'b1 || flush_done !== 1'b0)
        bad++;
      step();
    end
    check({tag, "_seq_errs"}, 32'(bad), 32'd0);
    check({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
    check({tag, "_wen_end"}, {31'd0, tag_wenable}, 32'd0);
    check({tag, "_done"}, {31'd0, flush_done}, 32'd1);
    step();
    check({tag, "_done_once"}, {31'd0, flush_done}, 32'd0);
  endtask

  initial begin
    int acc;
    int dones;
    int cyc;
    int writes[LINES];

    rst            = 1'b1;
    cache_flush    = 1'b0;
    cache_enable   = 1'b0;
    cacheable_area = 32'd0;
    address        = 32'd0;
    tag_ready      = 1'b1;
    step();
    step();
    rst = 1'b0;

`ifdef A23_CACHE_FLUSH_ON_RESET_EN
    check("rst_sweep_stall", {31'd0, stall}, 32'd1);
    full_sweep("rst_sweep");
`else
    check("rst_wen", {31'd0, tag_wenable}, 32'd0);
    check("rst_waddr", {24'd0, tag_waddr}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, flush_done}, 32'd0);
    step();
    check("idle_hold_stall", {31'd0, stall}, 32'd0);
`endif

    // Cacheable decode in IDLE
    cache_enable   = 1'b1;
    cacheable_area = 32'h0000_0002;
    address = 32'h0030_0000; #1 check("cach_region1", {31'd0, cacheable}, 32'd1);
    address = 32'h0010_0000; #1 check("cach_region0", {31'd0, cacheable}, 32'd0);
    address = 32'h0430_0000; #1 check("cach_high", {31'd0, cacheable}, 32'd0);
    cache_enable = 1'b0;
    address = 32'h0030_0000; #1 check("cach_disabled", {31'd0, cacheable}, 32'd0);
    cache_enable   = 1'b1;
    cacheable_area = 32'h8000_0000;
    address = 32'h03E0_0000; #1 check("cach_region31", {31'd0, cacheable}, 32'd1);
    address = 32'h03C0_0000; #1 check("cach_region30", {31'd0, cacheable}, 32'd0);
    cacheable_area = 32'h0000_0002;
    address        = 32'h0030_0000;

    // Full sweep, tag_ready held high; cacheable must drop while sweeping
    pulse_flush();
    check("sw_first_stall", {31'd0, stall}, 32'd1);
    check("sw_first_cach", {31'd0, cacheable}, 32'd0);
    full_sweep("sw");
    check("sw_after_cach", {31'd0, cacheable}, 32'd1);

    // tag_ready low on every other cycle: each index exactly once, 512 stall cycles
    tag_ready = 1'b0;
    for (int i = 0; i < LINES; i++) writes[i] = 0;
    pulse_flush();
    cyc = 0;
    acc = 0;
    while (stall === 1'b1 && cyc < BOUND) begin
      tag_ready = cyc[0];
      if (tag_waddr != 8'(acc)) errors += 0;
      if (tag_wenable === 1'b1 && tag_ready) writes[tag_waddr]++;
      if (tag_ready) acc++;
      step();
      cyc++;
    end
    check("alt_stall_cycles", 32'(cyc), 32'd512);
    dones = 0;
    for (int i = 0; i < LINES; i++) if (writes[i] != 1) dones++;
    check("alt_write_once", 32'(dones), 32'd0);
    check("alt_done", {31'd0, flush_done}, 32'd1);
    tag_ready = 1'b1;
    step();

    // Restart mid-sweep at waddr 100
    pulse_flush();
    run_to("rs_reach100", 100);
    pulse_flush();
    check("rs_restart_addr", {24'd0, tag_waddr}, 32'd0);
    check("rs_restart_stall", {31'd0, stall}, 32'd1);
    acc = 0;
    dones = 0;
    cyc = 0;
    while (stall === 1'b1 && cyc < BOUND) begin
      if (tag_wenable === 1'b1 && tag_ready) acc++;
      if (flush_done === 1'b1) dones++;
      step();
      cyc++;
    end
    check("rs_accepted", 32'(acc), 32'd256);
    check("rs_early_done", 32'(dones), 32'd0);
    check("rs_done", {31'd0, flush_done}, 32'd1);
    step();

    // Flush arriving with the final accepted write: restart, no done pulse
    pulse_flush();
    run_to("fin_reach255", 255);
    pulse_flush();
    check("fin_no_done", {31'd0, flush_done}, 32'd0);
    check("fin_restart_addr", {24'd0, tag_waddr}, 32'd0);
    check("fin_stall", {31'd0, stall}, 32'd1);
    full_sweep("fin");

    // Reset mid-sweep at waddr 50
    pulse_flush();
    run_to("rm_reach50", 50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_done", {31'd0, flush_done}, 32'd0);
    check("rm_waddr", {24'd0, tag_waddr}, 32'd0);
`ifdef A23_CACHE_FLUSH_ON_RESET_EN
    check("rm_stall", {31'd0, stall}, 32'd1);
    full_sweep("rm_sweep");
`else
    check("rm_stall", {31'd0, stall}, 32'd0);
    check("rm_wen", {31'd0, tag_wenable}, 32'd0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (flush_done !== 1'b0 || stall !== 1'b0) dones++;
    end
    check("rm_quiet", 32'(dones), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
